// File: rtl/add_pipe_pkg.sv
// add_pipe_pkg: shared parameters, stage-count helper and per-stage control record for add_pipe.
package add_pipe_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SEG   = 4;

    function automatic int stages_of(input int width, input int seg);
        return (seg > 0) ? (width / seg) : 1;
    endfunction

    // Valid bit is the stage's EMPTY/FULL state; carry is the carry out of the segment it added.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

endpackage

// File: rtl/add_pipe_if.sv
// add_pipe_if: operand/result handshake bundle for add_pipe.
// The ovf signal exists only when ADD_PIPE_OVF_EN is defined.
interface add_pipe_if
    import add_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG   = DEF_SEG
);
    localparam int STAGES = stages_of(WIDTH, SEG);

    // Valid/ready: a transfer happens on a rising clk edge where valid and ready are both 1;
    // the sender keeps valid and data stable until that edge, and ready may depend on valid.
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              ci;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  s;
    logic              co;
`ifdef ADD_PIPE_OVF_EN
    logic              ovf;
`endif
    logic [STAGES-1:0] dbg_valid;

    modport slave (
        input  in_valid, a, b, ci, out_ready,
        output in_ready, out_valid, s, co,
`ifdef ADD_PIPE_OVF_EN
        output ovf,
`endif
        output dbg_valid
    );

    modport master (
        output in_valid, a, b, ci, out_ready,
        input  in_ready, out_valid, s, co,
`ifdef ADD_PIPE_OVF_EN
        input  ovf,
`endif
        input  dbg_valid
    );

endinterface

// File: rtl/add_seg.sv
// add_seg: combinational SEG-bit adder slice, {co, s} = a + b + ci.
module add_seg #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};

endmodule

// File: rtl/add_pipe.sv
// add_pipe: pipelined segmented ripple-carry adder, one SEG-bit segment per stage, global-stall handshake.
// Optional signed overflow output is built when ADD_PIPE_OVF_EN is defined.
module add_pipe
    import add_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG   = DEF_SEG
) (
    input logic       clk,
    input logic       rst_n,
    add_pipe_if.slave bus
);

    localparam int STAGES = stages_of(WIDTH, SEG);
    localparam int LAST   = STAGES - 1;

    if (SEG < 1) begin : g_bad_seg
        $fatal(1, "add_pipe: SEG must be positive");
    end else if ((WIDTH % SEG) != 0) begin : g_bad_width
        $fatal(1, "add_pipe: WIDTH must be a multiple of SEG");
    end

    // Data widths follow the module parameters, so the record is completed here around the shared control part.
    typedef struct packed {
        stage_ctl_t       ctl;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] a_rem;
        logic [WIDTH-1:0] b_rem;
    } stage_t;

    stage_t            st      [STAGES];
    stage_t            nxt_arr [STAGES];
    logic              adv;
    logic [STAGES-1:0] valid_vec;

    assign adv          = ~st[LAST].ctl.valid | bus.out_ready;
    assign bus.in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t         src;
        stage_t         nxt;
        logic [SEG-1:0] seg_s;
        logic           seg_c;

        if (k == 0) begin : g_head
            always_comb begin
                src           = '0;
                src.ctl.valid = bus.in_valid;
                src.ctl.carry = bus.ci;
                src.a_rem     = bus.a;
                src.b_rem     = bus.b;
            end
        end else begin : g_body
            assign src = st[k-1];
        end

        add_seg #(.SEG(SEG)) u_seg (
            .a  (src.a_rem[k*SEG +: SEG]),
            .b  (src.b_rem[k*SEG +: SEG]),
            .ci (src.ctl.carry),
            .s  (seg_s),
            .co (seg_c)
        );

        // Everything passes through unchanged except this stage's sum segment and its carry.
        always_comb begin
            nxt                   = src;
            nxt.ctl.carry         = seg_c;
            nxt.sum[k*SEG +: SEG] = seg_s;
        end

        assign nxt_arr[k] = nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                st[k] <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                st[k] <= nxt_arr[k];
            end
        end
    end

    always_comb begin
        valid_vec = '0;
        for (int k = 0; k < STAGES; k++) begin
            valid_vec[k] = st[k].ctl.valid;
        end
    end

    assign bus.dbg_valid = valid_vec;
    assign bus.out_valid = st[LAST].ctl.valid;
    assign bus.s         = st[LAST].sum;
    assign bus.co        = st[LAST].ctl.carry;

`ifdef ADD_PIPE_OVF_EN
    // Carry into the MSB recovered from the MSB sum bit and operand bits; XOR with co gives signed overflow.
    logic msb_c_d;
    logic msb_c_q;

    assign msb_c_d = nxt_arr[LAST].a_rem[WIDTH-1] ^ nxt_arr[LAST].b_rem[WIDTH-1] ^ nxt_arr[LAST].sum[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msb_c_q <= 1'b0;
        end else if (adv) begin
            msb_c_q <= msb_c_d;
        end
    end

    assign bus.ovf = msb_c_q ^ st[LAST].ctl.carry;
`endif

endmodule

// File: tb/tb_add_pipe.sv
// tb_add_pipe: directed and randomized checks of add_pipe (16/4 and 8/8 builds) against an arithmetic reference model.
// Honours ADD_PIPE_OVF_EN for the ovf output.
module tb_add_pipe;
    import add_pipe_pkg::*;

`ifdef ADD_PIPE_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    add_pipe_if #(.WIDTH(16), .SEG(4)) b16 ();
    add_pipe_if #(.WIDTH(8),  .SEG(8)) b8 ();

    add_pipe #(.WIDTH(16), .SEG(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));
    add_pipe #(.WIDTH(8),  .SEG(8)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

    logic ovf16;
    logic ovf8;
`ifdef ADD_PIPE_OVF_EN
    assign ovf16 = b16.ovf;
    assign ovf8  = b8.ovf;
`else
    assign ovf16 = 1'b0;
    assign ovf8  = 1'b0;
`endif

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc_n    = 0;
    bit          chk_lat  = 1'b1;
    logic [17:0] exp_q[$];     // {ovf, co, s zero-extended to 16}
    int          acc_q[$];

    logic        o_valid;
    logic        o_ready;
    logic [17:0] o_res;
    logic [3:0]  o_dbg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned and signed integer arithmetic on w-bit operands.
    function automatic logic [17:0] model(input int w, input logic [15:0] av, input logic [15:0] bv, input logic civ);
        longint      half;
        longint      u;
        longint      sa;
        longint      sb;
        longint      ssum;
        logic [17:0] r;
        half = longint'(1) << (w - 1);
        u    = longint'(av) + longint'(bv) + longint'(civ);
        sa   = (longint'(av) >= half) ? longint'(av) - 2 * half : longint'(av);
        sb   = (longint'(bv) >= half) ? longint'(bv) - 2 * half : longint'(bv);
        ssum = sa + sb + longint'(civ);
        r        = '0;
        r[15:0]  = 16'(u % (2 * half));
        r[16]    = (u >= 2 * half);
        r[17]    = OVF_ON && ((ssum >= half) || (ssum < -half));
        return r;
    endfunction

    task automatic observe(input int sel);
        if (sel == 0) begin
            o_valid = b16.out_valid;
            o_ready = b16.in_ready;
            o_res   = {ovf16, b16.co, b16.s};
            o_dbg   = b16.dbg_valid;
        end else begin
            o_valid = b8.out_valid;
            o_ready = b8.in_ready;
            o_res   = {ovf8, b8.co, 8'h00, b8.s};
            o_dbg   = {3'b000, b8.dbg_valid};
        end
    endtask

    // ---------------- driver: one clock cycle on the selected DUT ----------------
    task automatic cyc(input int sel, input logic iv, input logic [15:0] av, input logic [15:0] bv,
                       input logic civ, input logic ordy, input logic use_model, input logic [17:0] dexp,
                       output logic acc);
        logic [17:0] e;
        int          t_acc;
        @(negedge clk);
        cyc_n++;
        if (sel == 0) begin
            b16.in_valid = iv; b16.a = av; b16.b = bv; b16.ci = civ; b16.out_ready = ordy;
            b8.in_valid = 1'b0; b8.out_ready = 1'b1;
        end else begin
            b8.in_valid = iv; b8.a = av[7:0]; b8.b = bv[7:0]; b8.ci = civ; b8.out_ready = ordy;
            b16.in_valid = 1'b0; b16.out_ready = 1'b1;
        end
        #1;
        observe(sel);
        chk("in_ready_rule", 32'(o_ready), 32'(!o_valid || ordy));
        if (exp_q.size() == 0) begin
            chk("no_unexpected_out", 32'(o_valid), 32'd0);
        end else if (o_valid && ordy) begin
            e     = exp_q.pop_front();
            t_acc = acc_q.pop_front();
            chk("result", 32'(o_res), 32'(e));
            if (chk_lat) chk("latency", 32'(cyc_n - t_acc), (sel == 0) ? 32'd4 : 32'd1);
        end
        acc = iv && o_ready;
        if (acc) begin
            exp_q.push_back(use_model ? model((sel == 0) ? 16 : 8, av, bv, civ) : dexp);
            acc_q.push_back(cyc_n);
        end
    endtask

    task automatic drain(input int sel);
        logic acc;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
            cyc(sel, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1, 18'h0, acc);
        end
        chk("drained", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic        acc;
        logic        pend;
        logic [15:0] pa;
        logic [15:0] pb;
        logic        pc;

        rst_n = 1'b0;
        b16.in_valid = 1'b0; b16.a = '0; b16.b = '0; b16.ci = 1'b0; b16.out_ready = 1'b0;
        b8.in_valid  = 1'b0; b8.a  = '0; b8.b  = '0; b8.ci  = 1'b0; b8.out_ready  = 1'b0;

        // Reset state
        #12;
        observe(0);
        chk("rst16_valid", 32'(o_valid), 32'd0);
        chk("rst16_data", 32'(o_res), 32'd0);
        chk("rst16_in_ready", 32'(o_ready), 32'd1);
        chk("rst16_dbg", 32'(o_dbg), 32'd0);
        observe(1);
        chk("rst8_valid", 32'(o_valid), 32'd0);
        chk("rst8_data", 32'(o_res), 32'd0);
        chk("rst8_in_ready", 32'(o_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 18'h0, acc);
        chk("in_ready_after_release", 32'(o_ready), 32'd1);

        // Carry ripple through all four segments
        cyc(0, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0, {1'b0, 1'b1, 16'h0000}, acc);
        drain(0);

        // Back-to-back throughput
        cyc(0, 1'b1, 16'h0001, 16'h0002, 1'b0, 1'b1, 1'b0, {1'b0, 1'b0, 16'h0003}, acc);
        cyc(0, 1'b1, 16'h00FF, 16'h0001, 1'b1, 1'b1, 1'b0, {1'b0, 1'b0, 16'h0101}, acc);
        cyc(0, 1'b1, 16'h8000, 16'h8000, 1'b0, 1'b1, 1'b0, {OVF_ON, 1'b1, 16'h0000}, acc);
        // Signed overflow boundaries
        cyc(0, 1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0, {OVF_ON, 1'b0, 16'h8000}, acc);
        cyc(0, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0, {1'b0, 1'b1, 16'h0000}, acc);
        drain(0);

        // Backpressure: fill while stalled, hold 5 cycles, then release
        chk_lat = 1'b0;
        pa = '0; pb = '0; pc = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pa = 16'($urandom); pb = 16'($urandom); pc = 1'($urandom_range(0, 1));
            cyc(0, 1'b1, pa, pb, pc, 1'b0, 1'b1, 18'h0, acc);
            if (!acc) break;
        end
        chk("fill_count", 32'(exp_q.size()), 32'd4);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1'b1, pa, pb, pc, 1'b0, 1'b1, 18'h0, acc);
            chk("stall_in_ready", 32'(o_ready), 32'd0);
            chk("stall_valid", 32'(o_valid), 32'd1);
            chk("stall_hold", 32'(o_res), 32'(exp_q[0]));
        end
        cyc(0, 1'b1, pa, pb, pc, 1'b1, 1'b1, 18'h0, acc);
        chk("release_accept", 32'(acc), 32'd1);
        drain(0);

        // Random traffic with random backpressure
        pend = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend = 1'b1;
                pa = 16'($urandom); pb = 16'($urandom); pc = 1'($urandom_range(0, 1));
            end
            cyc(0, pend, pa, pb, pc, 1'($urandom_range(0, 3) != 0), 1'b1, 18'h0, acc);
            if (acc) pend = 1'b0;
        end
        drain(0);

        // Asynchronous reset with operands in flight
        chk_lat = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b1, 1'b1, 18'h0, acc);
        end
        cyc(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 18'h0, acc);
        @(negedge clk);
        #1;
        observe(0);
        chk("pre_reset_valid", 32'(o_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        observe(0);
        chk("midrst_valid", 32'(o_valid), 32'd0);
        chk("midrst_data", 32'(o_res), 32'd0);
        chk("midrst_in_ready", 32'(o_ready), 32'd1);
        chk("midrst_dbg", 32'(o_dbg), 32'd0);
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1, 18'h0, acc);
        end

        // Single-stage build: 1000 random vectors, latency 1
        for (int i = 0; i < 1000; i++) begin
            cyc(1, 1'b1, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), 1'b1, 1'b1, 18'h0, acc);
        end
        drain(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: summary not reached within time limit");
        $fatal(1, "timeout");
    end

endmodule
